// File: rtl/tx_byte_feeder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tx_byte_feeder
//  Purpose  : Upstream stage of the UART TX control block. Buffers host bytes
//             in a small FIFO and, on a frame request, hands exactly Frame_Len
//             bytes to the TX control one at a time via the
//             Send_Sig / TX_Data / TX_Done_Sig handshake.
//  Ports    : CLK, RSTn (async, active low)
//             Wr_En/Wr_Data            - FIFO write side
//             Fifo_Full/Empty/Count    - FIFO status (registered count)
//             Overflow                 - pulse: write dropped on full FIFO
//             Frame_Start/Frame_Len    - frame request and byte count
//             Send_Sig/TX_Data         - byte hand-off to TX control
//             TX_Done_Sig              - TX control status (1 = idle/done)
//             readyFlag_TX/Busy        - frame active / FSM not idle
//             Underrun                 - frame waiting on an empty FIFO
//             Frame_Done/Err           - pulses: normal end / ack timeout
//  Revision : 1.0 - initial release
// ============================================================================
module tx_byte_feeder #(
  parameter int DEPTH       = 16,
  parameter int ADDR_W      = 4,
  parameter int ACK_TIMEOUT = 1024
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              Wr_En,
  input  logic [7:0]        Wr_Data,
  output logic              Fifo_Full,
  output logic              Fifo_Empty,
  output logic [ADDR_W:0]   Fifo_Count,
  output logic              Overflow,
  input  logic              Frame_Start,
  input  logic [15:0]       Frame_Len,
  output logic              Send_Sig,
  output logic [7:0]        TX_Data,
  input  logic              TX_Done_Sig,
  output logic              readyFlag_TX,
  output logic              Busy,
  output logic              Underrun,
  output logic              Frame_Done,
  output logic              Err
);

  localparam int                c_TO_W     = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [c_TO_W-1:0] c_TO_LAST  = c_TO_W'(ACK_TIMEOUT - 1);
  localparam logic [c_TO_W-1:0] c_TO_ONE   = c_TO_W'(1);
  localparam logic [ADDR_W:0]   c_FULL_CNT = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   c_CNT_ONE  = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] c_PTR_ONE  = ADDR_W'(1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD      = 3'd1,
    S_SEND      = 3'd2,
    S_WAIT_ACK  = 3'd3,
    S_WAIT_DONE = 3'd4
  } state_t;

  state_t              r_state, w_next;

  logic [7:0]          r_mem [DEPTH];
  logic [ADDR_W-1:0]   r_wptr, r_rptr;
  logic [ADDR_W:0]     r_count;
  logic                r_overflow, r_ready, r_frame_done, r_err;
  logic [7:0]          r_tx_data;
  logic [15:0]         r_remain;
  logic [c_TO_W-1:0]   r_to_cnt;

  logic w_full, w_empty, w_wr, w_pop;
  logic w_accept, w_byte_done, w_last, w_timeout;

  // Flags come from the registered count, so a write in the same cycle as a
  // pop at full is still refused.
  assign w_full  = (r_count == c_FULL_CNT);
  assign w_empty = (r_count == '0);
  assign w_wr    = Wr_En && !w_full;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // --------------------------------------------------------------------------
  // FSM: next state and strobes
  // --------------------------------------------------------------------------
  always_comb begin
    w_next      = r_state;
    w_pop       = 1'b0;
    w_accept    = 1'b0;
    w_byte_done = 1'b0;
    w_last      = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (Frame_Start && (Frame_Len != 16'd0)) begin
          w_accept = 1'b1;
          w_next   = S_LOAD;
        end
      end
      S_LOAD: begin
        if (!w_empty) begin
          w_pop  = 1'b1;
          w_next = S_SEND;
        end
      end
      S_SEND: w_next = S_WAIT_ACK;
      S_WAIT_ACK: begin
        if (!TX_Done_Sig) begin
          w_next = S_WAIT_DONE;
        end else if (r_to_cnt == c_TO_LAST) begin
          w_timeout = 1'b1;
          w_next    = S_IDLE;
        end
      end
      S_WAIT_DONE: begin
        if (TX_Done_Sig) begin
          w_byte_done = 1'b1;
          if (r_remain == 16'd1) begin
            w_last = 1'b1;
            w_next = S_IDLE;
          end else begin
            w_next = S_LOAD;
          end
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FIFO storage (contents need no reset: pointers define validity)
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (w_wr) r_mem[r_wptr] <= Wr_Data;
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= Wr_En && w_full;
      if (w_wr)  r_wptr <= r_wptr + c_PTR_ONE;
      if (w_pop) r_rptr <= r_rptr + c_PTR_ONE;
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + c_CNT_ONE;
        2'b01:   r_count <= r_count - c_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Frame datapath: byte register, remaining count, ack timeout, pulses
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_tx_data    <= 8'h00;
      r_remain     <= 16'd0;
      r_to_cnt     <= '0;
      r_ready      <= 1'b0;
      r_frame_done <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_frame_done <= w_last;
      r_err        <= w_timeout;

      // TX_Data only moves on a pop, which only happens while TX control
      // reports idle, so it is stable for the whole transmit.
      if (w_pop) r_tx_data <= r_mem[r_rptr];

      if (w_accept)         r_remain <= Frame_Len;
      else if (w_byte_done) r_remain <= r_remain - 16'd1;

      if (r_state == S_SEND)          r_to_cnt <= '0;
      else if (r_state == S_WAIT_ACK) r_to_cnt <= r_to_cnt + c_TO_ONE;

      if (w_accept)               r_ready <= 1'b1;
      else if (w_last || w_timeout) r_ready <= 1'b0;
    end
  end

  assign Fifo_Full    = w_full;
  assign Fifo_Empty   = w_empty;
  assign Fifo_Count   = r_count;
  assign Overflow     = r_overflow;
  assign Send_Sig     = (r_state == S_SEND);
  assign TX_Data      = r_tx_data;
  assign readyFlag_TX = r_ready;
  assign Busy         = (r_state != S_IDLE);
  assign Underrun     = (r_state == S_LOAD) && w_empty;
  assign Frame_Done   = r_frame_done;
  assign Err          = r_err;

endmodule
`default_nettype wire
